// File: rtl/pipe_interlock_pkg.sv
// Shared types and default constants for the pipeline hazard interlock.
// Scoreboard entries carry a fixed-width destination field wide enough for any supported RA_W.
package pipe_pkg;

  localparam int RA_W_MAX     = 8;
  localparam int DEF_DEPTH    = 3;
  localparam int DEF_LOAD_IDX = 1;
  localparam int DEF_BR_IDX   = 1;
  localparam int FWD_W        = $clog2(DEF_DEPTH + 1);

  typedef struct packed {
    logic                v;
    logic                wr;
    logic [RA_W_MAX-1:0] rd;
    logic                ld;
  } sb_entry_t;

endpackage

// File: rtl/pipe_interlock_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_interlock.sv
// Hazard interlock: scoreboard of in-flight instructions after ID producing stall, flush,
// per-stage kill and operand-forwarding selects, plus saturating stall/flush counters.
module pipe_interlock
  import pipe_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int LOAD_IDX = DEF_LOAD_IDX,
  parameter int BR_IDX   = DEF_BR_IDX,
  parameter int CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       id_valid_i,
  input  logic [RA_W-1:0]            id_rs_i,
  input  logic [RA_W-1:0]            id_rt_i,
  input  logic                       id_use_rs_i,
  input  logic                       id_use_rt_i,
  input  logic                       id_wr_en_i,
  input  logic [RA_W-1:0]            id_rd_i,
  input  logic                       id_is_load_i,
  input  logic                       br_taken_i,
  output logic                       stall_if_o,
  output logic                       stall_id_o,
  output logic                       flush_id_o,
  output logic [DEPTH-1:0]           kill_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_a_sel_o,
  output logic [$clog2(DEPTH+1)-1:0] fwd_b_sel_o,
  output logic [CNT_W-1:0]           stall_cnt_o,
  output logic [CNT_W-1:0]           flush_cnt_o
);

  localparam int SW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH-1:0] sb_q, sb_d;

  logic [RA_W_MAX-1:0] rs_ext, rt_ext, rd_ext;
  logic [DEPTH-1:0]    match_a, match_b;
  logic [DEPTH:0][SW-1:0] sel_a, sel_b;
  logic [DEPTH:0]      hz_a, hz_b;
  logic                stall;

  always_comb begin
    rs_ext = '0;
    rt_ext = '0;
    rd_ext = '0;
    rs_ext[RA_W-1:0] = id_rs_i;
    rt_ext[RA_W-1:0] = id_rt_i;
    rd_ext[RA_W-1:0] = id_rd_i;
  end

  // Priority chains run from the oldest entry down so index 0 (youngest) wins.
  assign sel_a[DEPTH] = '0;
  assign sel_b[DEPTH] = '0;
  assign hz_a[DEPTH]  = 1'b0;
  assign hz_b[DEPTH]  = 1'b0;

  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    localparam bit EARLY = (k < LOAD_IDX);
    assign match_a[k] = id_valid_i & id_use_rs_i & sb_q[k].v & sb_q[k].wr &
                        (rs_ext != '0) & (sb_q[k].rd == rs_ext);
    assign match_b[k] = id_valid_i & id_use_rt_i & sb_q[k].v & sb_q[k].wr &
                        (rt_ext != '0) & (sb_q[k].rd == rt_ext);
    assign sel_a[k] = match_a[k] ? SW'(k + 1) : sel_a[k+1];
    assign sel_b[k] = match_b[k] ? SW'(k + 1) : sel_b[k+1];
    assign hz_a[k]  = match_a[k] ? (EARLY & sb_q[k].ld) : hz_a[k+1];
    assign hz_b[k]  = match_b[k] ? (EARLY & sb_q[k].ld) : hz_b[k+1];
  end

  // A taken branch overrides load-use: the stalled instruction is flushed anyway.
  assign stall = (hz_a[0] | hz_b[0]) & ~br_taken_i;

  for (genvar k = 0; k < DEPTH; k++) begin : g_kill
    if (k == 0) begin : g_k0
      assign kill_o[k] = br_taken_i | stall;
    end else if (k <= BR_IDX) begin : g_kbr
      assign kill_o[k] = br_taken_i;
    end else begin : g_knone
      assign kill_o[k] = 1'b0;
    end
  end

  always_comb begin
    sb_d = '0;
    if (id_valid_i && !kill_o[0]) begin
      sb_d[0].v  = 1'b1;
      sb_d[0].wr = id_wr_en_i;
      sb_d[0].rd = rd_ext;
      sb_d[0].ld = id_is_load_i;
    end
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = kill_o[k] ? '0 : sb_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign stall_if_o  = stall;
  assign stall_id_o  = stall;
  assign flush_id_o  = br_taken_i;
  assign fwd_a_sel_o = sel_a[0];
  assign fwd_b_sel_o = sel_b[0];

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall),
    .count_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (br_taken_i),
    .count_o (flush_cnt_o)
  );

endmodule
